// File: rtl/ads_emu.sv
// ADC emulator: conversion timing, serial readout of latched samples and
// capture of a serial configuration word, all on the single system clock.
module ads_emu #(
    parameter int CONV_CYCLES = 85,
    parameter int FRAME_BITS  = 16
) (
    input  logic        CLK_100M,
    input  logic        CLK_RST,
    input  logic        ADS_CLK,
    input  logic        ADS_CS_N,
    input  logic        ADS_CONVST,
    input  logic        ADS_RD,
    input  logic        ADS_SDI,
    input  logic [1:0]  ADS_M,
    input  logic        PAT_SEL,
    input  logic [15:0] DIN_A,
    input  logic [15:0] DIN_B,
    output logic        ADS_BUSY,
    output logic        ADS_SDOA,
    output logic        ADS_SDOB,
    output logic [15:0] CFG_WORD,
    output logic        CFG_VALID,
    output logic        CONV_ERR
);

    localparam int W      = FRAME_BITS;
    localparam int IDX_W  = $clog2(2 * W);
    localparam int N_SYNC = 5;
    localparam logic [IDX_W-1:0] LAST_DUAL   = IDX_W'(W - 1);
    localparam logic [IDX_W-1:0] LAST_SINGLE = IDX_W'(2 * W - 1);
    localparam logic [7:0]       CNT_LOAD    = 8'(CONV_CYCLES - 1);

    typedef enum logic {C_IDLE = 1'b0, C_CONV = 1'b1} conv_state_t;
    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} shift_state_t;

    // ---------------- input synchronisers ----------------
    logic [N_SYNC-1:0] async_vec;
    logic [N_SYNC-1:0] sync_vec;
    assign async_vec = {ADS_SDI, ADS_RD, ADS_CONVST, ADS_CS_N, ADS_CLK};

    genvar gi;
    generate
        for (gi = 0; gi < N_SYNC; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge CLK_100M) begin
                if (!CLK_RST) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_vec[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    logic sclk_s, cs_n_s, convst_s, rd_s, sdi_s;
    assign {sdi_s, rd_s, convst_s, cs_n_s, sclk_s} = sync_vec;

    logic sclk_prev_reg, convst_prev_reg;
    always_ff @(posedge CLK_100M) begin
        if (!CLK_RST) begin
            sclk_prev_reg   <= 1'b0;
            convst_prev_reg <= 1'b0;
        end else begin
            sclk_prev_reg   <= sclk_s;
            convst_prev_reg <= convst_s;
        end
    end

    logic sclk_rise, sclk_fall, convst_rise;
    assign sclk_rise   = sclk_s & ~sclk_prev_reg;
    assign sclk_fall   = ~sclk_s & sclk_prev_reg;
    assign convst_rise = convst_s & ~convst_prev_reg;

    // ---------------- conversion FSM ----------------
    conv_state_t c_state_reg, c_state_next;
    logic [7:0]   conv_cnt_reg;
    logic [W-1:0] smp_a_reg, smp_b_reg;
    logic [15:0]  pat_cnt_reg;
    logic         data_rdy_reg;
    logic         conv_err_reg;
    logic         conv_start, conv_done, conv_reject;
    logic         frame_start;

    always_ff @(posedge CLK_100M) begin
        if (!CLK_RST) c_state_reg <= C_IDLE;
        else          c_state_reg <= c_state_next;
    end

    always_comb begin
        c_state_next = c_state_reg;
        case (c_state_reg)
            C_IDLE: if (convst_rise) c_state_next = C_CONV;
            C_CONV: if (conv_cnt_reg == 8'd0) c_state_next = C_IDLE;
            default: c_state_next = C_IDLE;
        endcase
    end

    // A start edge landing on the completion cycle is rejected too.
    always_comb begin
        ADS_BUSY    = (c_state_reg == C_CONV);
        conv_start  = (c_state_reg == C_IDLE) && convst_rise;
        conv_reject = (c_state_reg == C_CONV) && convst_rise;
        conv_done   = (c_state_reg == C_CONV) && (conv_cnt_reg == 8'd0);
    end

    logic [W-1:0] smp_src_a, smp_src_b;
    assign smp_src_a = PAT_SEL ? W'(pat_cnt_reg)  : W'(DIN_A);
    assign smp_src_b = PAT_SEL ? W'(~pat_cnt_reg) : W'(DIN_B);

    always_ff @(posedge CLK_100M) begin
        if (!CLK_RST) begin
            conv_cnt_reg <= 8'd0;
            smp_a_reg    <= '0;
            smp_b_reg    <= '0;
            pat_cnt_reg  <= 16'd0;
            data_rdy_reg <= 1'b0;
            conv_err_reg <= 1'b0;
        end else begin
            conv_err_reg <= conv_reject;
            if (conv_start)
                conv_cnt_reg <= CNT_LOAD;
            else if ((c_state_reg == C_CONV) && (conv_cnt_reg != 8'd0))
                conv_cnt_reg <= conv_cnt_reg - 8'd1;
            if (conv_done) begin
                smp_a_reg    <= smp_src_a;
                smp_b_reg    <= smp_src_b;
                pat_cnt_reg  <= pat_cnt_reg + 16'd1;
                data_rdy_reg <= 1'b1;
            end else if (frame_start) begin
                data_rdy_reg <= 1'b0;
            end
        end
    end

    assign CONV_ERR = conv_err_reg;

    // ---------------- shift FSM ----------------
    shift_state_t s_state_reg, s_state_next;
    logic [2*W-1:0]   shr_a_reg;
    logic [W-1:0]     shr_b_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic             single_reg;
    logic             last_bit, shift_step;

    assign frame_start = (s_state_reg == S_IDLE) && sclk_rise && !cs_n_s && rd_s
                         && data_rdy_reg && !ADS_BUSY;
    assign last_bit    = (bit_idx_reg == (single_reg ? LAST_SINGLE : LAST_DUAL));
    assign shift_step  = (s_state_reg == S_SHIFT) && !cs_n_s && sclk_rise && !last_bit;

    always_ff @(posedge CLK_100M) begin
        if (!CLK_RST) s_state_reg <= S_IDLE;
        else          s_state_reg <= s_state_next;
    end

    always_comb begin
        s_state_next = s_state_reg;
        case (s_state_reg)
            S_IDLE:  if (frame_start) s_state_next = S_SHIFT;
            S_SHIFT: begin
                if (cs_n_s)
                    s_state_next = S_IDLE;
                else if (sclk_rise && last_bit)
                    s_state_next = S_IDLE;
            end
            default: s_state_next = S_IDLE;
        endcase
    end

    // Single-lane mode chains both samples through lane A.
    always_ff @(posedge CLK_100M) begin
        if (!CLK_RST) begin
            shr_a_reg   <= '0;
            shr_b_reg   <= '0;
            bit_idx_reg <= '0;
            single_reg  <= 1'b0;
        end else if (frame_start) begin
            shr_a_reg   <= (ADS_M == 2'b01) ? {smp_a_reg, smp_b_reg} : {smp_a_reg, {W{1'b0}}};
            shr_b_reg   <= smp_b_reg;
            bit_idx_reg <= '0;
            single_reg  <= (ADS_M == 2'b01);
        end else if (shift_step) begin
            shr_a_reg   <= {shr_a_reg[2*W-2:0], 1'b0};
            shr_b_reg   <= {shr_b_reg[W-2:0], 1'b0};
            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
        end
    end

    always_comb begin
        ADS_SDOA = 1'b0;
        ADS_SDOB = 1'b0;
        if (s_state_reg == S_SHIFT) begin
            ADS_SDOA = shr_a_reg[2*W-1];
            ADS_SDOB = single_reg ? 1'b0 : shr_b_reg[W-1];
        end
    end

    // ---------------- configuration input ----------------
    logic [15:0] sdi_sr_reg;
    logic [3:0]  sdi_cnt_reg;

    always_ff @(posedge CLK_100M) begin
        if (!CLK_RST) begin
            sdi_sr_reg  <= 16'd0;
            sdi_cnt_reg <= 4'd0;
            CFG_WORD    <= 16'd0;
            CFG_VALID   <= 1'b0;
        end else begin
            CFG_VALID <= 1'b0;
            if (cs_n_s) begin
                sdi_cnt_reg <= 4'd0;
            end else if (sclk_fall) begin
                sdi_sr_reg  <= {sdi_sr_reg[14:0], sdi_s};
                sdi_cnt_reg <= sdi_cnt_reg + 4'd1;
                if (sdi_cnt_reg == 4'd15) begin
                    CFG_WORD  <= {sdi_sr_reg[14:0], sdi_s};
                    CFG_VALID <= 1'b1;
                end
            end
        end
    end

endmodule
